// File: rtl/ethernet_pkg.sv
// Shared definitions for the Ethernet PHY configuration slice.
// Holds the SMI register map constants used during bring-up, the
// configuration table entry type with its default contents, and the
// state encoding of the ethernet_phy_config sequencer.
package ethernet_pkg;

    localparam logic [4:0] SMI_REG_BMCR        = 5'd0;
    localparam logic [4:0] SMI_REG_ANAR        = 5'd4;
    localparam logic [4:0] SMI_REG_PLACEHOLDER = 5'd31;

    localparam int BMCR_RESET_BIT      = 15;
    localparam int BMCR_AN_ENABLE_BIT  = 12;
    localparam int BMCR_AN_RESTART_BIT = 9;

    localparam logic [15:0] BMCR_RESET      = 16'h8000;
    localparam logic [15:0] BMCR_AN_ENABLE  = 16'h1000;
    localparam logic [15:0] BMCR_AN_RESTART = 16'h0200;

    // 10BASE-T / 100BASE-TX, full and half duplex, IEEE 802.3 selector
    localparam logic [15:0] ANAR_10_100_ALL = 16'h01E1;

    typedef struct packed {
        logic [4:0]  reg_addr;
        logic [15:0] data;
    } cfg_entry_t;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ISSUE   = 3'd1;
    localparam logic [2:0] ST_RELEASE = 3'd2;
    localparam logic [2:0] ST_SETTLE  = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;
    localparam logic [2:0] ST_ERROR   = 3'd5;

    function automatic cfg_entry_t default_entry(input logic [2:0] idx);
        cfg_entry_t e;
        case (idx)
            3'd0:    e = '{reg_addr: SMI_REG_BMCR, data: BMCR_RESET};
            3'd1:    e = '{reg_addr: SMI_REG_ANAR, data: ANAR_10_100_ALL};
            3'd2:    e = '{reg_addr: SMI_REG_BMCR, data: BMCR_AN_ENABLE | BMCR_AN_RESTART};
            default: e = '{reg_addr: SMI_REG_PLACEHOLDER, data: 16'h0000};
        endcase
        return e;
    endfunction

endpackage

// File: rtl/ethernet_phy_config_rom.sv
// Combinational lookup of the PHY bring-up table.
// Ports:
//   step     in   3   table index
//   reg_addr out  5   PHY register address of that entry
//   data     out  16  write data of that entry
module ethernet_phy_config_rom
    import ethernet_pkg::*;
(
    input  logic [2:0]  step,
    output logic [4:0]  reg_addr,
    output logic [15:0] data
);

    cfg_entry_t entry;

    always_comb begin
        entry = default_entry(step);
    end

    assign reg_addr = entry.reg_addr;
    assign data     = entry.data;

endmodule

// File: rtl/ethernet_phy_config.sv
// Power-up configuration sequencer for the Ethernet PHY. Walks the
// bring-up table and issues each write through ethernet_smi with the
// init/ready handshake, waits a settle time after a PHY soft reset and
// flags a sticky error if the SMI engine stalls.
// Ports:
//   clk, reset         system clock, synchronous active-high reset
//   start              single-cycle pulse, accepted only when idle
//   busy               sequence in progress
//   done, error        sticky completion / SMI timeout flags
//   step               index of the entry being issued
//   smi_init           command request to ethernet_smi
//   smi_register/_content  address and write data of the command
//   smi_ready          completion from ethernet_smi
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start
// ISSUE   | smi_init high, command held until smi_ready rises
// RELEASE | smi_init low, waiting for smi_ready to fall
// SETTLE  | waiting out the PHY soft-reset recovery time
// DONE    | one-cycle completion, returns to IDLE
// ERROR   | one-cycle SMI timeout, returns to IDLE
module ethernet_phy_config
    import ethernet_pkg::*;
#(
    parameter int NUM_ENTRIES       = 3,
    parameter int RESET_WAIT_CYCLES = 1000000,
    parameter int TIMEOUT_CYCLES    = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [2:0]  step,
    output logic        smi_init,
    output logic [4:0]  smi_register,
    output logic [15:0] smi_content,
    input  logic        smi_ready
);

    localparam int CNT_MAX = (RESET_WAIT_CYCLES > TIMEOUT_CYCLES) ? RESET_WAIT_CYCLES
                                                                  : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    // Counter starts at 0 on state entry, so the last cycle of an N-cycle
    // window is N-1.
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(RESET_WAIT_CYCLES - 1);
    localparam logic [2:0]       LAST_STEP    = 3'(NUM_ENTRIES - 1);

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       rom_reg;
    logic [15:0]      rom_data;
    logic             settle_needed;
    logic             last_step;
    logic             step_inc;
    logic             set_done;
    logic             set_error;
    logic             accept_start;

    ethernet_phy_config_rom u_rom (
        .step     (step),
        .reg_addr (rom_reg),
        .data     (rom_data)
    );

    assign settle_needed = (rom_reg == SMI_REG_BMCR) && rom_data[BMCR_RESET_BIT];
    assign last_step     = (step == LAST_STEP);

    always_comb begin
        state_nxt    = state;
        step_inc     = 1'b0;
        set_done     = 1'b0;
        set_error    = 1'b0;
        accept_start = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt    = ST_ISSUE;
                    accept_start = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (smi_ready) begin
                    state_nxt = ST_RELEASE;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_nxt = ST_ERROR;
                    set_error = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (!smi_ready) begin
                    if (settle_needed) begin
                        state_nxt = ST_SETTLE;
                    end else if (last_step) begin
                        state_nxt = ST_DONE;
                        set_done  = 1'b1;
                    end else begin
                        state_nxt = ST_ISSUE;
                        step_inc  = 1'b1;
                    end
                end else if (cnt == TIMEOUT_LAST) begin
                    state_nxt = ST_ERROR;
                    set_error = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    if (last_step) begin
                        state_nxt = ST_DONE;
                        set_done  = 1'b1;
                    end else begin
                        state_nxt = ST_ISSUE;
                        step_inc  = 1'b1;
                    end
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            ST_ERROR: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            step  <= 3'd0;
            done  <= 1'b0;
            error <= 1'b0;
        end else begin
            state <= state_nxt;

            // Every state change restarts the shared window; saturation keeps
            // a long wait from wrapping back into a false terminal count.
            if (state_nxt != state) begin
                cnt <= '0;
            end else if (cnt != '1) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (accept_start) begin
                step  <= 3'd0;
                done  <= 1'b0;
                error <= 1'b0;
            end else begin
                if (step_inc) begin
                    step <= step + 3'd1;
                end
                if (set_done) begin
                    done <= 1'b1;
                end
                if (set_error) begin
                    error <= 1'b1;
                end
            end
        end
    end

    // Command outputs are decoded from the registered state, so smi_init
    // drops on the very edge that samples smi_ready or reset.
    assign smi_init     = (state == ST_ISSUE);
    assign busy         = (state == ST_ISSUE) || (state == ST_RELEASE) || (state == ST_SETTLE);
    assign smi_register = smi_init ? rom_reg  : 5'd0;
    assign smi_content  = smi_init ? rom_data : 16'd0;

endmodule

// File: tb/tb_ethernet_phy_config.sv
module tb_ethernet_phy_config;

    localparam int RW          = 20;
    localparam int TO          = 64;
    localparam int READY_DELAY = 40;
    localparam int DROP_DELAY  = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic        error;
    logic [2:0]  step;
    logic        smi_init;
    logic [4:0]  smi_register;
    logic [15:0] smi_content;
    logic        smi_ready = 1'b0;

    int checks = 0;
    int errors = 0;
    int ncyc   = 0;
    // 0: nominal, 1: never ready on command 1, 2: ready stuck after command 0
    int mode   = 0;

    logic [20:0] log_cmd[$];
    int          rise_cyc[$];
    int          fall_cyc[$];

    ethernet_phy_config #(
        .NUM_ENTRIES       (3),
        .RESET_WAIT_CYCLES (RW),
        .TIMEOUT_CYCLES    (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .step         (step),
        .smi_init     (smi_init),
        .smi_register (smi_register),
        .smi_content  (smi_content),
        .smi_ready    (smi_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Behavioural SMI engine, updated on the falling edge.
    int hi_cnt = 0;
    int lo_cnt = 0;
    int cmd_seen = 0;
    logic init_q = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            smi_ready = 1'b0;
            hi_cnt    = 0;
            lo_cnt    = 0;
            cmd_seen  = 0;
            init_q    = 1'b0;
        end else begin
            if (smi_init && !init_q) cmd_seen++;
            init_q = smi_init;
            if (smi_init) begin
                lo_cnt = 0;
                hi_cnt++;
                if (hi_cnt == READY_DELAY && !(mode == 1 && cmd_seen == 2)) smi_ready = 1'b1;
            end else begin
                hi_cnt = 0;
                if (smi_ready) begin
                    lo_cnt++;
                    if (lo_cnt == DROP_DELAY && mode != 2) begin
                        smi_ready = 1'b0;
                        lo_cnt    = 0;
                    end
                end
            end
        end
    end

    // Command logger and handshake checker, sampled after the model update.
    logic        prev_init = 1'b0;
    logic        prev_ready = 1'b0;
    logic [4:0]  prev_reg = '0;
    logic [15:0] prev_data = '0;
    always @(negedge clk) begin
        #1;
        ncyc++;
        if (reset) begin
            prev_init  = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (smi_init && !prev_init) begin
                log_cmd.push_back({smi_register, smi_content});
                rise_cyc.push_back(ncyc);
            end
            if (!smi_init && prev_init) fall_cyc.push_back(ncyc);
            if (mode == 0) begin
                if (smi_init && prev_init) begin
                    chk("reg_stable", 32'(smi_register), 32'(prev_reg));
                    chk("data_stable", 32'(smi_content), 32'(prev_data));
                end
                if (prev_init && prev_ready) chk("init_drop_after_ready", 32'(smi_init), 32'(0));
                if (prev_init && !smi_init) chk("ready_before_init_drop", 32'(prev_ready), 32'(1));
            end
            prev_init  = smi_init;
            prev_ready = smi_ready;
            prev_reg   = smi_register;
            prev_data  = smi_content;
        end
    end

    function automatic logic [20:0] log_at(input int i);
        if (log_cmd.size() > i) return log_cmd[i];
        return '1;
    endfunction

    task automatic clear_log();
        log_cmd.delete();
        rise_cyc.delete();
        fall_cyc.delete();
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #2;
    endtask

    task automatic wait_end(input string tag, output int end_cyc);
        for (int i = 0; i < 1000; i++) begin
            if (done || error) break;
            @(negedge clk);
            #2;
        end
        end_cyc = ncyc;
        chk(tag, 32'(done || error), 32'(1));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'(0));
        chk({tag, "_done"}, 32'(done), 32'(0));
        chk({tag, "_error"}, 32'(error), 32'(0));
        chk({tag, "_step"}, 32'(step), 32'(0));
        chk({tag, "_init"}, 32'(smi_init), 32'(0));
        chk({tag, "_reg"}, 32'(smi_register), 32'(0));
        chk({tag, "_data"}, 32'(smi_content), 32'(0));
    endtask

    task automatic chk_three_cmds(input string tag);
        chk({tag, "_count"}, 32'(log_cmd.size()), 32'(3));
        chk({tag, "_cmd0"}, 32'(log_at(0)), 32'({5'd0, 16'h8000}));
        chk({tag, "_cmd1"}, 32'(log_at(1)), 32'({5'd4, 16'h01E1}));
        chk({tag, "_cmd2"}, 32'(log_at(2)), 32'({5'd0, 16'h1200}));
    endtask

    int end_cyc;
    int gap;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        #2;
        chk_all_zero("reset");
        reset = 1'b0;

        // Nominal sequence
        mode = 0;
        clear_log();
        pulse_start();
        chk("latency_init", 32'(smi_init), 32'(1));
        chk("latency_busy", 32'(busy), 32'(1));
        chk("first_reg", 32'(smi_register), 32'(0));
        chk("first_data", 32'(smi_content), 32'(16'h8000));
        wait_end("nominal_end", end_cyc);
        chk("nominal_done", 32'(done), 32'(1));
        chk("nominal_busy", 32'(busy), 32'(0));
        chk("nominal_error", 32'(error), 32'(0));
        chk_three_cmds("nominal");
        gap = (rise_cyc.size() > 1 && fall_cyc.size() > 0) ? rise_cyc[1] - fall_cyc[0] : 0;
        chk("settle_gap_ge_20", 32'(gap >= RW), 32'(1));
        repeat (3) @(negedge clk);
        #2;
        chk("done_sticky", 32'(done), 32'(1));
        chk("idle_busy", 32'(busy), 32'(0));

        // Start during busy
        clear_log();
        pulse_start();
        chk("start_clears_done", 32'(done), 32'(0));
        repeat (10) @(negedge clk);
        #2;
        chk("busy_mid_issue", 32'(busy), 32'(1));
        pulse_start();
        repeat (50) @(negedge clk);
        #2;
        chk("busy_mid_settle", 32'(busy), 32'(1));
        pulse_start();
        wait_end("busy_start_end", end_cyc);
        chk("busy_start_done", 32'(done), 32'(1));
        chk_three_cmds("busy_start");

        // ISSUE timeout on entry 1
        do_reset();
        mode = 1;
        clear_log();
        pulse_start();
        wait_end("issue_to_end", end_cyc);
        chk("issue_to_error", 32'(error), 32'(1));
        chk("issue_to_done", 32'(done), 32'(0));
        chk("issue_to_step", 32'(step), 32'(1));
        chk("issue_to_init", 32'(smi_init), 32'(0));
        chk("issue_to_busy", 32'(busy), 32'(0));
        gap = (rise_cyc.size() > 1) ? end_cyc - rise_cyc[1] : 0;
        chk("issue_to_cycles", 32'(gap), 32'(TO));

        // RELEASE timeout with ready stuck high
        do_reset();
        mode = 2;
        clear_log();
        pulse_start();
        wait_end("release_to_end", end_cyc);
        chk("release_to_error", 32'(error), 32'(1));
        chk("release_to_done", 32'(done), 32'(0));
        chk("release_to_step", 32'(step), 32'(0));
        gap = (fall_cyc.size() > 0) ? end_cyc - fall_cyc[0] : 0;
        chk("release_to_cycles", 32'(gap), 32'(TO));

        // Reset mid-SETTLE, then re-run
        do_reset();
        mode = 0;
        clear_log();
        pulse_start();
        for (int i = 0; i < 200; i++) begin
            if (fall_cyc.size() > 0) break;
            @(negedge clk);
            #2;
        end
        chk("settle_reached", 32'(fall_cyc.size() > 0), 32'(1));
        repeat (5) @(negedge clk);
        #2;
        chk("in_settle_busy", 32'(busy), 32'(1));
        chk("in_settle_init", 32'(smi_init), 32'(0));
        reset = 1'b1;
        @(negedge clk);
        #2;
        chk_all_zero("settle_reset");
        reset = 1'b0;
        clear_log();
        pulse_start();
        chk("rerun_step", 32'(step), 32'(0));
        wait_end("rerun_end", end_cyc);
        chk("rerun_done", 32'(done), 32'(1));
        chk("rerun_error", 32'(error), 32'(0));
        chk_three_cmds("rerun");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
